timer_service_master: RTL and testbench
=======================================

// Module: timer_service_master
// PURPOSE
//  Avalon-MM master that drives the interval timer slave of the AlarmClock system.
//  Programs the period and control registers, then waits for the timer irq.
//  On each irq it reads status, clears the timeout and advances an hh:mm:ss time-of-day counter.
//  Sits between the timer slave and the display/alarm logic, so the 1 Hz tick needs no CPU.
// PARAMETERS
//  DATA_W          16            bus data width; must match the timer slave
//  ADDR_W          3             bus word address width
//  DEFAULT_PERIOD  32'h02FAF07F  period written on auto-config after reset (50 MHz -> 1 s)
//  CTRL_RUN        4'b0111       control word written: START|CONT|ITO
// PORTS
//  clk            in   1       system clock
//  reset_n        in   1       asynchronous, active-low reset
//  m_address      out  ADDR_W  timer register word address
//  m_chipselect   out  1       bus transfer valid
//  m_write_n      out  1       0 = write, 1 = read
//  m_writedata    out  DATA_W  write data
//  m_readdata     in   DATA_W  read data, registered in slave: valid 1 cycle after the address cycle
//  irq_in         in   1       timer interrupt, level
//  cfg_start      in   1       pulse: reprogram timer with period_cfg
//  period_cfg     in   32      period for cfg_start (ticks-1)
//  set_time       in   1       pulse: load set_hh/set_mm/set_ss
//  set_hh,set_mm,set_ss in 5,6,6  time to load
//  alarm_on       in   1       alarm armed
//  alarm_hh,alarm_mm,alarm_ss in 5,6,6  alarm time
//  hh,mm,ss       out  5,6,6   current time; reset 0:00:00
//  tick           out  1       1-cycle pulse per serviced timeout; reset 0
//  alarm_fire     out  1       1-cycle pulse on alarm match; reset 0
//  busy           out  1       1 when FSM is not in IDLE/WAIT_IRQ; reset 0
//  spurious_cnt   out  8       irqs with status.TO=0; saturates at 255; reset 0
// BEHAVIOUR
//  Bus: one transfer per cycle, no waitrequest. Idle bus: chipselect=0, write_n=1, address=0, writedata=0.
//  FSM: IDLE -> CFG_PL -> CFG_PH -> CFG_CTL -> WAIT_IRQ -> RD_STAT -> RD_WAIT -> {CLR_STAT -> TICK | WAIT_IRQ}.
//  IDLE: entered on reset. Next cycle auto-configures with DEFAULT_PERIOD.
//  CFG_PL: write addr 2 <= period[15:0].
//  CFG_PH: write addr 3 <= period[31:16].
//  CFG_CTL: write addr 1 <= CTRL_RUN. Config sequence is 3 consecutive write cycles.
//  WAIT_IRQ: irq_in=1 -> RD_STAT. A pending cfg_start -> CFG_PL, and cfg_start has priority over irq_in.
//  RD_STAT: read addr 0.
//  RD_WAIT: bus idle; sample m_readdata[0].
//    TO=1 -> CLR_STAT.
//    TO=0 -> spurious_cnt++ and return to WAIT_IRQ.
//  CLR_STAT: write addr 0 <= 0 (clears TO).
//  TICK: bus idle; covers the cycle before irq_in falls, so no double count. Asserts tick, advances time, -> WAIT_IRQ.
//  Latency: irq_in rise to tick is 4 cycles (WAIT_IRQ sample, RD_STAT, RD_WAIT, CLR_STAT; tick in TICK).
//  cfg_start outside WAIT_IRQ: latched, period_cfg captured at the pulse, serviced on next WAIT_IRQ. A second pulse overwrites.
//  Time: ss 0..59, mm 0..59, hh 0..23. Carries ripple in the same cycle; 23:59:59 + tick -> 00:00:00.
//  set_time: load is applied the next cycle. If set_time coincides with TICK, the load wins and that tick's increment is dropped (tick still pulses).
//  Out-of-range set values are clamped to the maximum (hh>23 -> 23, mm/ss>59 -> 59).
//  Reset mid-transfer: all outputs return to reset values immediately, FSM -> IDLE, pending cfg cleared; the timer is re-configured afterwards.
// CONFIGURATION
//  ALARM_MATCH_EN defined:
//    alarm_fire pulses in the cycle after TICK when alarm_on=1 and the new time equals alarm_hh:mm:ss.
//    A set_time load never fires the alarm.
//  ALARM_MATCH_EN undefined: alarm_fire is tied to 0 and the alarm_* inputs are ignored.
// STRUCTURE
//  Package timer_regs_pkg:
//    register address constants ADDR_STATUS=0, ADDR_CONTROL=1, ADDR_PERIODL=2, ADDR_PERIODH=3
//    control bit indices ITO=0, CONT=1, START=2, STOP=3
//    status bit TO=0
//    FSM state enum
//  Sub-module tod_counter: hh:mm:ss register, increment, set and clamp logic (instanced once).
// TESTING
//  Reset release -> writes (2,0xF07F), (3,0x02FA), (1,0x7) on consecutive cycles, then bus idle, busy=0.
//  irq_in rises with readdata[0]=1 -> read addr 0, write addr 0 data 0, tick 4 cycles after the rise; ss 0 -> 1.
//  irq_in high with readdata[0]=0 -> no clear write, no tick, spurious_cnt 0 -> 1; 300 such irqs -> 255.
//  set_time 23:59:59 then one serviced irq -> hh:mm:ss = 00:00:00, tick=1.
//  cfg_start with period_cfg=0x0000_1387 during RD_WAIT -> current service completes, then writes (2,0x1387), (3,0x0000), (1,0x7).
//  ALARM_MATCH_EN, alarm_on=1, alarm 00:00:05, 5 ticks from 0 -> one alarm_fire pulse; undefined -> alarm_fire stays 0.

Source files
------------

// File: rtl/timer_regs_pkg.sv
// timer_regs_pkg: register map, control/status bit positions, FSM state
// encoding and small helpers shared by timer_service_master and tod_counter.
package timer_regs_pkg;

  // Interval timer register word addresses
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;

  // Control register bit indices
  localparam int ITO   = 0;
  localparam int CONT  = 1;
  localparam int START = 2;
  localparam int STOP  = 3;

  // Status register bit index
  localparam int TO = 0;

  // Control words: run continuously with interrupt; STOP is never sent with START
  localparam logic [3:0] CTRL_RUN_DEF   = (4'b0001 << START) | (4'b0001 << CONT) | (4'b0001 << ITO);
  localparam logic [3:0] CTRL_STOP_MASK = 4'b0001 << STOP;

  // Time-of-day limits
  localparam logic [4:0] HH_MAX = 5'd23;
  localparam logic [5:0] MM_MAX = 6'd59;
  localparam logic [5:0] SS_MAX = 6'd59;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CFG_PL   = 4'd1,
    ST_CFG_PH   = 4'd2,
    ST_CFG_CTL  = 4'd3,
    ST_WAIT_IRQ = 4'd4,
    ST_RD_STAT  = 4'd5,
    ST_RD_WAIT  = 4'd6,
    ST_CLR_STAT = 4'd7,
    ST_TICK     = 4'd8
  } state_t;

  function automatic logic [4:0] clamp5(input logic [4:0] v, input logic [4:0] max_v);
    clamp5 = (v > max_v) ? max_v : v;
  endfunction

  function automatic logic [5:0] clamp6(input logic [5:0] v, input logic [5:0] max_v);
    clamp6 = (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/timer_service_master_tod_counter.sv
// tod_counter: hh:mm:ss time-of-day register with one-second increment
// (carries ripple in one cycle) and a clamped load that wins over increment.
module tod_counter
  import timer_regs_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_inc,
  input  logic       i_set,
  input  logic [4:0] i_set_hh,
  input  logic [5:0] i_set_mm,
  input  logic [5:0] i_set_ss,
  output logic [4:0] o_hh,
  output logic [5:0] o_mm,
  output logic [5:0] o_ss,
  output logic [4:0] o_nxt_hh,
  output logic [5:0] o_nxt_mm,
  output logic [5:0] o_nxt_ss
);

  logic [4:0] r_hh;
  logic [5:0] r_mm;
  logic [5:0] r_ss;
  logic [4:0] w_nxt_hh;
  logic [5:0] w_nxt_mm;
  logic [5:0] w_nxt_ss;

  // Time one second after the current value, with ss->mm->hh carry ripple
  always_comb begin
    w_nxt_hh = r_hh;
    w_nxt_mm = r_mm;
    w_nxt_ss = r_ss;
    if (r_ss >= SS_MAX) begin
      w_nxt_ss = 6'd0;
      if (r_mm >= MM_MAX) begin
        w_nxt_mm = 6'd0;
        if (r_hh >= HH_MAX) begin
          w_nxt_hh = 5'd0;
        end else begin
          w_nxt_hh = r_hh + 5'd1;
        end
      end else begin
        w_nxt_mm = r_mm + 6'd1;
      end
    end else begin
      w_nxt_ss = r_ss + 6'd1;
    end
  end

  // Time register: clamped load has priority over the increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hh <= 5'd0;
      r_mm <= 6'd0;
      r_ss <= 6'd0;
    end else if (i_set) begin
      r_hh <= clamp5(i_set_hh, HH_MAX);
      r_mm <= clamp6(i_set_mm, MM_MAX);
      r_ss <= clamp6(i_set_ss, SS_MAX);
    end else if (i_inc) begin
      r_hh <= w_nxt_hh;
      r_mm <= w_nxt_mm;
      r_ss <= w_nxt_ss;
    end
  end

  assign o_hh     = r_hh;
  assign o_mm     = r_mm;
  assign o_ss     = r_ss;
  assign o_nxt_hh = w_nxt_hh;
  assign o_nxt_mm = w_nxt_mm;
  assign o_nxt_ss = w_nxt_ss;

endmodule

// File: rtl/timer_service_master.sv
// timer_service_master: Avalon-MM master that programs the interval timer,
// services each timeout interrupt and advances an hh:mm:ss time of day.
// Optional feature macro: ALARM_MATCH_EN enables the alarm_fire comparator;
// without it alarm_fire is tied low and the alarm_* inputs are ignored.
module timer_service_master
  import timer_regs_pkg::*;
#(
  parameter int          DATA_W         = 16,
  parameter int          ADDR_W         = 3,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h02FAF07F,
  parameter logic [3:0]  CTRL_RUN       = CTRL_RUN_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              irq_in,
  input  logic              cfg_start,
  input  logic [31:0]       period_cfg,
  input  logic              set_time,
  input  logic [4:0]        set_hh,
  input  logic [5:0]        set_mm,
  input  logic [5:0]        set_ss,
  input  logic              alarm_on,
  input  logic [4:0]        alarm_hh,
  input  logic [5:0]        alarm_mm,
  input  logic [5:0]        alarm_ss,
  output logic [4:0]        hh,
  output logic [5:0]        mm,
  output logic [5:0]        ss,
  output logic              tick,
  output logic              alarm_fire,
  output logic              busy,
  output logic [7:0]        spurious_cnt
);

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_period, w_period_nxt;
  logic              r_pend, w_pend_nxt;
  logic [31:0]       r_pend_period, w_pend_period_nxt;
  logic              w_spur_inc;
  logic [ADDR_W-1:0] r_address, w_address;
  logic              r_chipselect, w_chipselect;
  logic              r_write_n, w_write_n;
  logic [DATA_W-1:0] r_writedata, w_writedata;
  logic              r_tick, r_busy, r_alarm_fire;
  logic [7:0]        r_spurious;
  logic              w_in_tick, w_alarm_hit;
  logic [4:0]        w_nxt_hh;
  logic [5:0]        w_nxt_mm, w_nxt_ss;
  logic              w_unused_rdata;

  assign w_in_tick = (r_state == ST_TICK);

  // Next-state, period selection, pending-config capture and spurious detect
  always_comb begin
    w_state_nxt       = r_state;
    w_period_nxt      = r_period;
    w_pend_nxt        = r_pend;
    w_pend_period_nxt = r_pend_period;
    w_spur_inc        = 1'b0;
    if (cfg_start) begin
      w_pend_nxt        = 1'b1;
      w_pend_period_nxt = period_cfg;
    end else begin
      w_pend_nxt        = r_pend;
    end
    case (r_state)
      ST_IDLE: begin
        w_state_nxt  = ST_CFG_PL;
        w_period_nxt = DEFAULT_PERIOD;
      end
      ST_CFG_PL:  w_state_nxt = ST_CFG_PH;
      ST_CFG_PH:  w_state_nxt = ST_CFG_CTL;
      ST_CFG_CTL: w_state_nxt = ST_WAIT_IRQ;
      ST_WAIT_IRQ: begin
        if (w_pend_nxt) begin
          w_state_nxt  = ST_CFG_PL;
          w_period_nxt = w_pend_period_nxt;
          w_pend_nxt   = 1'b0;
        end else if (irq_in) begin
          w_state_nxt = ST_RD_STAT;
        end else begin
          w_state_nxt = ST_WAIT_IRQ;
        end
      end
      ST_RD_STAT: w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (m_readdata[TO]) begin
          w_state_nxt = ST_CLR_STAT;
        end else begin
          w_state_nxt = ST_WAIT_IRQ;
          w_spur_inc  = 1'b1;
        end
      end
      ST_CLR_STAT: w_state_nxt = ST_TICK;
      ST_TICK:     w_state_nxt = ST_WAIT_IRQ;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Bus values for the upcoming cycle, decoded from the next state
  always_comb begin
    w_chipselect = 1'b0;
    w_write_n    = 1'b1;
    w_address    = '0;
    w_writedata  = '0;
    case (w_state_nxt)
      ST_CFG_PL: begin
        w_chipselect = 1'b1;
        w_write_n    = 1'b0;
        w_address    = ADDR_W'(ADDR_PERIODL);
        w_writedata  = DATA_W'(w_period_nxt[15:0]);
      end
      ST_CFG_PH: begin
        w_chipselect = 1'b1;
        w_write_n    = 1'b0;
        w_address    = ADDR_W'(ADDR_PERIODH);
        w_writedata  = DATA_W'(w_period_nxt[31:16]);
      end
      ST_CFG_CTL: begin
        w_chipselect = 1'b1;
        w_write_n    = 1'b0;
        w_address    = ADDR_W'(ADDR_CONTROL);
        w_writedata  = DATA_W'(CTRL_RUN & ~CTRL_STOP_MASK);
      end
      ST_RD_STAT: begin
        w_chipselect = 1'b1;
        w_address    = ADDR_W'(ADDR_STATUS);
      end
      ST_CLR_STAT: begin
        w_chipselect = 1'b1;
        w_write_n    = 1'b0;
        w_address    = ADDR_W'(ADDR_STATUS);
      end
      default: begin
        w_chipselect = 1'b0;
      end
    endcase
  end

  // FSM, period and pending-config registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_period      <= DEFAULT_PERIOD;
      r_pend        <= 1'b0;
      r_pend_period <= 32'h0000_0000;
    end else begin
      r_state       <= w_state_nxt;
      r_period      <= w_period_nxt;
      r_pend        <= w_pend_nxt;
      r_pend_period <= w_pend_period_nxt;
    end
  end

  // Registered bus and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_address    <= '0;
      r_chipselect <= 1'b0;
      r_write_n    <= 1'b1;
      r_writedata  <= '0;
      r_tick       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_address    <= w_address;
      r_chipselect <= w_chipselect;
      r_write_n    <= w_write_n;
      r_writedata  <= w_writedata;
      r_tick       <= (w_state_nxt == ST_TICK);
      r_busy       <= !((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_WAIT_IRQ));
    end
  end

  // Spurious-interrupt counter, saturating at 255
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_spurious <= 8'd0;
    end else if (w_spur_inc && (r_spurious != 8'hFF)) begin
      r_spurious <= r_spurious + 8'd1;
    end
  end

  tod_counter u_tod (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_inc    (w_in_tick),
    .i_set    (set_time),
    .i_set_hh (set_hh),
    .i_set_mm (set_mm),
    .i_set_ss (set_ss),
    .o_hh     (hh),
    .o_mm     (mm),
    .o_ss     (ss),
    .o_nxt_hh (w_nxt_hh),
    .o_nxt_mm (w_nxt_mm),
    .o_nxt_ss (w_nxt_ss)
  );

`ifdef ALARM_MATCH_EN
  // An increment that lands on the armed alarm time fires; a load never does
  assign w_alarm_hit = w_in_tick && !set_time && alarm_on &&
                       (w_nxt_hh == alarm_hh) && (w_nxt_mm == alarm_mm) && (w_nxt_ss == alarm_ss);
`else
  logic w_unused_alarm;
  assign w_alarm_hit    = 1'b0;
  assign w_unused_alarm = ^{alarm_on, alarm_hh, alarm_mm, alarm_ss, w_nxt_hh, w_nxt_mm, w_nxt_ss};
`endif

  // Alarm pulse register, aligned with the updated time
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alarm_fire <= 1'b0;
    end else begin
      r_alarm_fire <= w_alarm_hit;
    end
  end

  // Only the TO bit of the status word matters here
  assign w_unused_rdata = ^m_readdata[DATA_W-1:1];

  assign m_address    = r_address;
  assign m_chipselect = r_chipselect;
  assign m_write_n    = r_write_n;
  assign m_writedata  = r_writedata;
  assign tick         = r_tick;
  assign busy         = r_busy;
  assign alarm_fire   = r_alarm_fire;
  assign spurious_cnt = r_spurious;

endmodule

// File: tb/tb_timer_service_master.sv
// tb_timer_service_master: randomized self-checking bench. A seconds-of-day
// reference model and per-cycle expected bus words are derived from the
// timer-service behaviour and compared against the DUT on every negedge.
`timescale 1ns/1ps
module tb_timer_service_master;

  localparam logic [31:0] DEF_P = 32'h02FAF07F;
`ifdef ALARM_MATCH_EN
  localparam bit ALARM_EN = 1'b1;
`else
  localparam bit ALARM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  m_address;
  logic        m_chipselect, m_write_n;
  logic [15:0] m_writedata;
  logic [15:0] m_readdata = 16'h0000;
  logic        irq_in = 1'b0, cfg_start = 1'b0, set_time = 1'b0, alarm_on = 1'b0;
  logic [31:0] period_cfg = 32'h0;
  logic [4:0]  set_hh = 5'd0, alarm_hh = 5'd0;
  logic [5:0]  set_mm = 6'd0, set_ss = 6'd0, alarm_mm = 6'd0, alarm_ss = 6'd5;
  logic [4:0]  hh;
  logic [5:0]  mm, ss;
  logic        tick, alarm_fire, busy;
  logic [7:0]  spurious_cnt;

  timer_service_master dut (
    .clk(clk), .reset_n(reset_n), .m_address(m_address), .m_chipselect(m_chipselect),
    .m_write_n(m_write_n), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .irq_in(irq_in), .cfg_start(cfg_start), .period_cfg(period_cfg),
    .set_time(set_time), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .alarm_on(alarm_on), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_ss(alarm_ss),
    .hh(hh), .mm(mm), .ss(ss), .tick(tick), .alarm_fire(alarm_fire), .busy(busy),
    .spurious_cnt(spurious_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int tod      = 0;   // model: seconds since midnight
  int spur     = 0;   // model: spurious count
  int alarm_sec = 5;
  int fires_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ew(input logic fire, input logic tk, input logic bsy,
                                     input logic cs, input logic wn, input logic [2:0] a,
                                     input logic [15:0] d);
    return {8'd0, fire, tk, bsy, cs, wn, a, d};
  endfunction

  function automatic logic [31:0] obs();
    return {8'd0, alarm_fire, tick, busy, m_chipselect, m_write_n, m_address, m_writedata};
  endfunction

  function automatic logic [31:0] tod_word(input int t);
    logic [4:0] h;
    logic [5:0] m, s;
    h = 5'(t / 3600);
    m = 6'((t / 60) % 60);
    s = 6'(t % 60);
    return {15'd0, h, m, s};
  endfunction

  function automatic int set_model(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    int hi, mi, si;
    hi = (int'(h) > 23) ? 23 : int'(h);
    mi = (int'(m) > 59) ? 59 : int'(m);
    si = (int'(s) > 59) ? 59 : int'(s);
    return hi * 3600 + mi * 60 + si;
  endfunction

  task automatic next_cyc();
    @(negedge clk);
    cfg_start = 1'b0;
    set_time  = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_time"}, {15'd0, hh, mm, ss}, tod_word(tod));
    check_eq({tag, "_spur"}, {24'd0, spurious_cnt}, 32'(spur));
  endtask

  // Three consecutive config writes, then idle bus with busy low
  task automatic expect_config(input logic [31:0] p);
    next_cyc(); check_eq("cfg_pl",  obs(), ew(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, p[15:0]));
    next_cyc(); check_eq("cfg_ph",  obs(), ew(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, p[31:16]));
    next_cyc(); check_eq("cfg_ctl", obs(), ew(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 16'h0007));
    next_cyc(); check_eq("cfg_done", obs(), ew(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000));
  endtask

  task automatic idle_cyc();
    next_cyc(); check_eq("idle", obs(), ew(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000));
  endtask

  task automatic set_pulse(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    set_time = 1'b1; set_hh = h; set_mm = m; set_ss = s;
    tod = set_model(h, m, s);
    idle_cyc();
    check_state("set");
  endtask

  // One irq service; readdata carries TO only in the cycle the status is sampled
  task automatic service(input logic to, input logic cfg_mid, input logic set_mid);
    logic fire;
    irq_in = 1'b1;
    m_readdata = 16'($urandom); m_readdata[0] = ~to;
    next_cyc(); check_eq("rd_stat", obs(), ew(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 16'h0000));
    next_cyc(); check_eq("rd_wait", obs(), ew(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 16'h0000));
    m_readdata = 16'($urandom); m_readdata[0] = to;
    if (cfg_mid) begin
      cfg_start = 1'b1; period_cfg = 32'h0000_1387;
    end
    if (!to) begin
      irq_in = 1'b0;
      if (spur < 255) spur++;
      next_cyc(); m_readdata = 16'($urandom);
      check_eq("spur_back", obs(), ew(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000));
      check_state("spur");
    end else begin
      next_cyc(); m_readdata = 16'($urandom); m_readdata[0] = 1'b0;
      check_eq("clr_stat", obs(), ew(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000));
      next_cyc();
      check_eq("tick", obs(), ew(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 16'h0000));
      irq_in = 1'b0;
      if (set_mid) begin
        set_time = 1'b1;
        set_hh = 5'($urandom_range(0, 31)); set_mm = 6'($urandom_range(0, 63));
        set_ss = 6'($urandom_range(0, 63));
        tod = set_model(set_hh, set_mm, set_ss);
        fire = 1'b0;
      end else begin
        tod = (tod + 1) % 86400;
        fire = ALARM_EN && alarm_on && (tod == alarm_sec);
      end
      next_cyc();
      if (alarm_fire) fires_seen++;
      check_eq("post_tick", obs(), ew(fire, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000));
      check_state("svc");
    end
  endtask

  initial begin
    logic [31:0] p;
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_bus", obs(), ew(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000));
    check_state("rst");
    reset_n = 1'b1;
    check_eq("idle_st", obs(), ew(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000));
    expect_config(DEF_P);
    idle_cyc(); idle_cyc();

    // First serviced timeout: ss 0 -> 1
    service(1'b1, 1'b0, 1'b0);

    // Spurious irqs saturate at 255
    for (int i = 0; i < 300; i++) service(1'b0, 1'b0, 1'b0);

    // Midnight wrap
    set_pulse(5'd23, 6'd59, 6'd59);
    service(1'b1, 1'b0, 1'b0);

    // Out-of-range set values clamp
    set_pulse(5'd31, 6'd63, 6'd60);

    // cfg_start during RD_WAIT: service completes, then reprogram
    service(1'b1, 1'b1, 1'b0);
    expect_config(32'h0000_1387);

    // set_time coinciding with TICK: load wins, tick still pulses
    service(1'b1, 1'b0, 1'b1);

    // cfg_start and irq together: config first, then the irq is serviced
    p = $urandom;
    irq_in = 1'b1; cfg_start = 1'b1; period_cfg = p;
    expect_config(p);
    service(1'b1, 1'b0, 1'b0);

    // Alarm at 00:00:05 after 5 ticks from midnight
    alarm_on = 1'b1;
    set_pulse(5'd0, 6'd0, 6'd0);
    fires_seen = 0;
    for (int i = 0; i < 5; i++) service(1'b1, 1'b0, 1'b0);
    check_eq("alarm_count", 32'(fires_seen), ALARM_EN ? 32'd1 : 32'd0);

    // Randomized mix
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0, 1: service(1'b1, 1'b0, 1'($urandom_range(0, 3) == 0));
        2: service(1'b0, 1'b0, 1'b0);
        3: set_pulse(5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        4: begin
          p = $urandom; cfg_start = 1'b1; period_cfg = p;
          expect_config(p);
        end
        default: idle_cyc();
      endcase
    end

    // Reset mid-transfer with a config pending
    set_pulse(5'd12, 6'd34, 6'd56);
    irq_in = 1'b1; m_readdata = 16'h0001;
    next_cyc(); check_eq("mr_rd", obs(), ew(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 16'h0000));
    cfg_start = 1'b1; period_cfg = 32'h0000_0100;
    next_cyc();
    @(posedge clk); #2;
    reset_n = 1'b0; #1;
    tod = 0; spur = 0; irq_in = 1'b0;
    check_eq("mr_bus", obs(), ew(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000));
    check_state("mr");
    @(negedge clk);
    reset_n = 1'b1;
    expect_config(DEF_P);
    repeat (3) idle_cyc();
    service(1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
